squash_gen: RTL and testbench
=============================

SQUASH_GEN -- requirements
Module: squash_gen

Interface
REQ-001 SHALL have parameter BRU_NUM, default 2, meaning the number of branch-writeback ports.
REQ-002 SHALL have port clk, input, 1, the single core clock.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port i_bwb_vld, input, BRU_NUM, branch-writeback valid per port.
REQ-005 SHALL have port i_bwb_info, input, BRU_NUM x branchwbInfo_t, branch-writeback payload.
REQ-006 SHALL have port i_vio_vld, input, 1, memory-ordering violation report valid.
REQ-007 SHALL have port i_vio_robIdx, input, robIdx_t, rob index of the violating load.
REQ-008 SHALL have port i_vio_pc, input, XLEN, pc of the violating load.
REQ-009 SHALL have port i_vio_st_foldpc / i_vio_ld_foldpc, input, MEMDEP_FOLDPC_WIDTH each, folded pcs of the store and the load.
REQ-010 SHALL have port i_retire_vld, input, 1, the oldest ROB instruction retires this cycle.
REQ-011 SHALL have port i_retire_robIdx, input, robIdx_t, rob index of the retiring instruction.
REQ-012 SHALL have port i_head_robIdx, input, robIdx_t, current ROB head index.
REQ-013 SHALL have port o_squash_vld, output, 1, squash pulse.
REQ-014 SHALL have port o_squash_info, output, squashInfo_t, squash payload.
REQ-015 SHALL have port o_pending, output, 1, a squash candidate is held.

Function
REQ-016 SHALL implement FSM IDLE -> PEND -> FIRE -> IDLE.
- IDLE: no candidate.
- PEND: one candidate held (kind, robIdx, arch_pc, taken, foldpcs).
- FIRE: one-cycle output.
REQ-017 SHALL accept a branch writeback as a candidate only if i_bwb_vld and has_mispred are both 1.
- Captured arch_pc = branch_npc.
- Captured branch_taken comes from the writeback payload.
REQ-018 SHALL accept a violation candidate only when i_vio_vld=1.
- Captured arch_pc = i_vio_pc (the load re-executes).
REQ-019 SHALL compare ages using flag+index.
- A is older than B iff (A.flg==B.flg and A.idx<B.idx) or (A.flg!=B.flg and A.idx>B.idx).
REQ-020 SHALL, in IDLE or PEND, select the oldest of all valid inputs and the held candidate, and hold the winner.
- Ties on the same robIdx: the held candidate wins; among inputs, the lower port index wins, and a branch wins over a violation.
REQ-021 SHALL move PEND -> FIRE under these conditions:
- Branch candidate: i_retire_vld=1 and i_retire_robIdx equals the held robIdx.
- Violation candidate: i_head_robIdx equals the held robIdx.
REQ-022 SHALL, in FIRE, drive o_squash_vld=1 for exactly one cycle.
- dueToBranch and dueToViolation come from the candidate kind.
- arch_pc and branch_taken come from the held candidate.
- Foldpcs are driven for a violation and zero for a branch.
REQ-023 SHALL ignore all writeback and violation inputs during FIRE, because they are younger and are squashed; the next state is IDLE with the candidate cleared.
REQ-024 SHALL have a latency from the trigger condition of REQ-021 to o_squash_vld of 1 cycle.
REQ-025 SHALL use combinational arbitration; a candidate presented in cycle N that also matches the trigger in cycle N is held in cycle N+1 and fires in cycle N+2.
REQ-026 SHALL assert o_pending=1 in PEND and in FIRE.
REQ-027 SHALL keep o_squash_info at all zeros whenever o_squash_vld=0.

Reset
REQ-028 SHALL, when rst=1, set state to IDLE and drive o_squash_vld=0, o_pending=0 and o_squash_info all zeros on the next edge.
REQ-029 SHALL, on a reset mid-PEND or mid-FIRE, discard the candidate with no squash pulse.

Configuration
REQ-030 SHALL compile the violation path only under SQUASH_GEN_VIOLATION_EN.
- Defined: violation ports exist and behave as in REQ-018 and REQ-021.
- Undefined: violation ports are absent, dueToViolation is constant 0, and foldpc outputs are constant 0.

Structure
REQ-031 SHALL place the candidate-kind enum and the robIdx age-compare function in the shared core package next to squashInfo_t.
REQ-032 SHALL implement the oldest-of-N selection as sub-module rob_age_sel, parameterized by input count.

Verification
REQ-033 SHALL verify: port0 mispred robIdx{0,5}, npc 0x8000_0100; retire {0,5} two cycles later -> one pulse, dueToBranch=1, arch_pc=0x8000_0100, the cycle after retire.
REQ-034 SHALL verify: same cycle, port0 mispred {0,9} and port1 mispred {0,4} -> {0,4} held; retire {0,9} gives no pulse.
REQ-035 SHALL verify wrap: hold {1,2}, then wb {0,60} mispred -> {0,60} older and replaces.
REQ-036 SHALL verify violation: load {0,7}, pc 0x8000_0200, foldpcs 0x1A/0x2B; head reaches {0,7} -> dueToViolation=1, arch_pc=0x8000_0200, foldpcs echoed.
REQ-037 SHALL verify: mispred {0,3} arriving during the FIRE cycle -> ignored, state IDLE, o_pending=0 afterwards.
REQ-038 SHALL verify: rst asserted while in PEND, then retire of the held index -> o_squash_vld stays 0.

Source files
------------

// File: rtl/squash_gen_pkg.sv
// Shared core types for squash generation: rob index, writeback and squash
// payloads, candidate kind and the rob age-compare helper.
package squash_gen_pkg;

   localparam int XLEN                = 32;
   localparam int ROB_IDX_W           = 6;
   localparam int MEMDEP_FOLDPC_WIDTH = 8;

   typedef struct packed {
      logic                 flg;
      logic [ROB_IDX_W-1:0] idx;
   } robIdx_t;

   typedef struct packed {
      robIdx_t           robIdx;
      logic              has_mispred;
      logic              branch_taken;
      logic [XLEN-1:0]   branch_npc;
   } branchwbInfo_t;

   typedef struct packed {
      logic                           dueToBranch;
      logic                           dueToViolation;
      logic [XLEN-1:0]                arch_pc;
      logic                           branch_taken;
      logic [MEMDEP_FOLDPC_WIDTH-1:0] st_foldpc;
      logic [MEMDEP_FOLDPC_WIDTH-1:0] ld_foldpc;
   } squashInfo_t;

   typedef enum logic {
      CAND_BRANCH = 1'b0,
      CAND_VIO    = 1'b1
   } cand_kind_e;

   typedef struct packed {
      cand_kind_e                     kind;
      robIdx_t                        robIdx;
      logic [XLEN-1:0]                arch_pc;
      logic                           taken;
      logic [MEMDEP_FOLDPC_WIDTH-1:0] st_foldpc;
      logic [MEMDEP_FOLDPC_WIDTH-1:0] ld_foldpc;
   } cand_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_FIRE = 2'd2
   } sq_state_e;

   // The flag bit toggles on every rob wrap, so differing flags invert the
   // sense of the index comparison.
   function automatic logic rob_is_older(robIdx_t a, robIdx_t b);
      if (a.flg == b.flg)
         return a.idx < b.idx;
      else
         return a.idx > b.idx;
   endfunction

endpackage

// File: rtl/rob_age_sel.sv
// Oldest-of-N selector over rob indices. Ports: vld/rob per input,
// any_vld when something is valid, sel = index of the oldest (ties -> lowest).
module rob_age_sel
   import squash_gen_pkg::*;
#(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic    [N-1:0] vld,
   input  robIdx_t [N-1:0] rob,
   output logic            any_vld,
   output logic [IW-1:0]   sel
);

   robIdx_t best;

   // Only a strictly older entry displaces the current best, so the lowest
   // index wins every tie.
   always_comb begin
      any_vld = 1'b0;
      sel     = '0;
      best    = '0;
      for (int i = 0; i < N; i++) begin
         if (vld[i] && (!any_vld || rob_is_older(rob[i], best))) begin
            any_vld = 1'b1;
            sel     = IW'(i);
            best    = rob[i];
         end
      end
   end

endmodule

// File: rtl/squash_gen.sv
// Squash generator: holds the oldest mispredict/violation candidate and
// emits a one-cycle squash once it reaches retire (branch) or rob head
// (violation). Ports: clk, rst (sync, high), i_bwb_*, i_vio_* (only with
// SQUASH_GEN_VIOLATION_EN), i_retire_*, i_head_robIdx, o_squash_vld,
// o_squash_info, o_pending.
module squash_gen
   import squash_gen_pkg::*;
#(
   parameter int BRU_NUM = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [BRU_NUM-1:0]             i_bwb_vld,
   input  branchwbInfo_t [BRU_NUM-1:0]    i_bwb_info,
`ifdef SQUASH_GEN_VIOLATION_EN
   input  logic                           i_vio_vld,
   input  robIdx_t                        i_vio_robIdx,
   input  logic [XLEN-1:0]                i_vio_pc,
   input  logic [MEMDEP_FOLDPC_WIDTH-1:0] i_vio_st_foldpc,
   input  logic [MEMDEP_FOLDPC_WIDTH-1:0] i_vio_ld_foldpc,
`endif
   input  logic                           i_retire_vld,
   input  robIdx_t                        i_retire_robIdx,
   input  robIdx_t                        i_head_robIdx,
   output logic                           o_squash_vld,
   output squashInfo_t                    o_squash_info,
   output logic                           o_pending
);

`ifdef SQUASH_GEN_VIOLATION_EN
   localparam int VIO_N = 1;
`else
   localparam int VIO_N = 0;
`endif
   // Slot 0 is the held candidate so it wins ties against new inputs.
   localparam int NUM_IN = 1 + BRU_NUM + VIO_N;
   localparam int IW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   sq_state_e state, state_nx;
   cand_t     held, held_nx;

   logic    [NUM_IN-1:0] in_vld;
   robIdx_t [NUM_IN-1:0] in_rob;
   cand_t                in_cand [NUM_IN];
   logic                 any_vld;
   logic [IW-1:0]        sel;
   cand_t                win;
   logic                 fire_hit;

   always_comb begin
      in_vld     = '0;
      in_rob     = '0;
      in_vld[0]  = (state == S_PEND);
      in_rob[0]  = held.robIdx;
      in_cand[0] = held;
      for (int p = 0; p < BRU_NUM; p++) begin
         in_vld[p+1]            = i_bwb_vld[p] & i_bwb_info[p].has_mispred;
         in_rob[p+1]            = i_bwb_info[p].robIdx;
         in_cand[p+1]           = '0;
         in_cand[p+1].kind      = CAND_BRANCH;
         in_cand[p+1].robIdx    = i_bwb_info[p].robIdx;
         in_cand[p+1].arch_pc   = i_bwb_info[p].branch_npc;
         in_cand[p+1].taken     = i_bwb_info[p].branch_taken;
      end
`ifdef SQUASH_GEN_VIOLATION_EN
      in_vld[NUM_IN-1]            = i_vio_vld;
      in_rob[NUM_IN-1]            = i_vio_robIdx;
      in_cand[NUM_IN-1]           = '0;
      in_cand[NUM_IN-1].kind      = CAND_VIO;
      in_cand[NUM_IN-1].robIdx    = i_vio_robIdx;
      in_cand[NUM_IN-1].arch_pc   = i_vio_pc;
      in_cand[NUM_IN-1].st_foldpc = i_vio_st_foldpc;
      in_cand[NUM_IN-1].ld_foldpc = i_vio_ld_foldpc;
`endif
   end

   rob_age_sel #(
      .N (NUM_IN)
   ) u_sel (
      .vld     (in_vld),
      .rob     (in_rob),
      .any_vld (any_vld),
      .sel     (sel)
   );

   assign win = in_cand[sel];

`ifdef SQUASH_GEN_VIOLATION_EN
   assign fire_hit = (held.kind == CAND_BRANCH)
                   ? (i_retire_vld && (i_retire_robIdx == held.robIdx))
                   : (i_head_robIdx == held.robIdx);
`else
   logic head_unused;
   assign head_unused = ^i_head_robIdx;
   assign fire_hit    = (held.kind == CAND_BRANCH)
                      && i_retire_vld
                      && (i_retire_robIdx == held.robIdx);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         held  <= '0;
      end else begin
         state <= state_nx;
         held  <= held_nx;
      end
   end

   // The trigger only looks at the registered candidate, so a new arrival
   // is held one cycle before it can fire.
   always_comb begin
      state_nx = state;
      held_nx  = held;
      unique case (state)
         S_IDLE: begin
            if (any_vld) begin
               state_nx = S_PEND;
               held_nx  = win;
            end
         end
         S_PEND: begin
            if (fire_hit)
               state_nx = S_FIRE;
            else if (any_vld)
               held_nx = win;
         end
         S_FIRE: begin
            state_nx = S_IDLE;
            held_nx  = '0;
         end
         default: begin
            state_nx = S_IDLE;
            held_nx  = '0;
         end
      endcase
   end

   always_comb begin
      o_squash_vld  = (state == S_FIRE);
      o_pending     = (state != S_IDLE);
      o_squash_info = '0;
      if (state == S_FIRE) begin
         o_squash_info.dueToBranch  = (held.kind == CAND_BRANCH);
         o_squash_info.arch_pc      = held.arch_pc;
         o_squash_info.branch_taken = held.taken;
`ifdef SQUASH_GEN_VIOLATION_EN
         o_squash_info.dueToViolation = (held.kind == CAND_VIO);
         if (held.kind == CAND_VIO) begin
            o_squash_info.st_foldpc = held.st_foldpc;
            o_squash_info.ld_foldpc = held.ld_foldpc;
         end
`endif
      end
   end

endmodule

// File: tb/tb_squash_gen.sv
// Directed self-checking bench for squash_gen; violation cases are
// compiled in only with SQUASH_GEN_VIOLATION_EN.
module tb_squash_gen;
   import squash_gen_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [1:0]               bwb_vld;
   branchwbInfo_t [1:0]      bwb_info;
`ifdef SQUASH_GEN_VIOLATION_EN
   logic                     vio_vld;
   robIdx_t                  vio_rob;
   logic [XLEN-1:0]          vio_pc;
   logic [7:0]               vio_st, vio_ld;
`endif
   logic                     ret_vld;
   robIdx_t                  ret_rob;
   robIdx_t                  head_rob;
   logic                     sq_vld;
   squashInfo_t              sq_info;
   logic                     pend;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   squash_gen #(.BRU_NUM(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_bwb_vld       (bwb_vld),
      .i_bwb_info      (bwb_info),
`ifdef SQUASH_GEN_VIOLATION_EN
      .i_vio_vld       (vio_vld),
      .i_vio_robIdx    (vio_rob),
      .i_vio_pc        (vio_pc),
      .i_vio_st_foldpc (vio_st),
      .i_vio_ld_foldpc (vio_ld),
`endif
      .i_retire_vld    (ret_vld),
      .i_retire_robIdx (ret_rob),
      .i_head_robIdx   (head_rob),
      .o_squash_vld    (sq_vld),
      .o_squash_info   (sq_info),
      .o_pending       (pend)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bwb_vld  = '0;
      bwb_info = '0;
`ifdef SQUASH_GEN_VIOLATION_EN
      vio_vld = 1'b0;
      vio_rob = '0;
      vio_pc  = '0;
      vio_st  = '0;
      vio_ld  = '0;
`endif
      ret_vld  = 1'b0;
      ret_rob  = '0;
      head_rob = 7'h3f;
   endtask

   task automatic wb(input int p, input logic f, input logic [5:0] i,
                     input logic [31:0] npc, input logic tk);
      bwb_vld[p]                  = 1'b1;
      bwb_info[p].robIdx.flg      = f;
      bwb_info[p].robIdx.idx      = i;
      bwb_info[p].has_mispred     = 1'b1;
      bwb_info[p].branch_taken    = tk;
      bwb_info[p].branch_npc      = npc;
   endtask

   task automatic retire(input logic f, input logic [5:0] i);
      ret_vld     = 1'b1;
      ret_rob.flg = f;
      ret_rob.idx = i;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      clr();
      do_rst();
      chk("rst_vld", 64'(sq_vld), 64'd0);
      chk("rst_pend", 64'(pend), 64'd0);
      chk("rst_info", 64'(sq_info), 64'd0);

      // basic branch mispredict
      wb(0, 1'b0, 6'd5, 32'h8000_0100, 1'b1);
      tick();
      clr();
      chk("b_pend", 64'(pend), 64'd1);
      chk("b_novld", 64'(sq_vld), 64'd0);
      tick();
      retire(1'b0, 6'd5);
      tick();
      clr();
      chk("b_vld", 64'(sq_vld), 64'd1);
      chk("b_dueB", 64'(sq_info.dueToBranch), 64'd1);
      chk("b_dueV", 64'(sq_info.dueToViolation), 64'd0);
      chk("b_pc", 64'(sq_info.arch_pc), 64'h8000_0100);
      chk("b_tk", 64'(sq_info.branch_taken), 64'd1);
      chk("b_fold", 64'({sq_info.st_foldpc, sq_info.ld_foldpc}), 64'd0);
      tick();
      chk("b_off", 64'(sq_vld), 64'd0);
      chk("b_idle", 64'(pend), 64'd0);
      chk("b_info0", 64'(sq_info), 64'd0);

      // two ports same cycle: {0,4} is older
      wb(0, 1'b0, 6'd9, 32'h9, 1'b0);
      wb(1, 1'b0, 6'd4, 32'h4, 1'b0);
      tick();
      clr();
      retire(1'b0, 6'd9);
      tick();
      clr();
      chk("two_no9", 64'(sq_vld), 64'd0);
      chk("two_pend", 64'(pend), 64'd1);
      retire(1'b0, 6'd4);
      tick();
      clr();
      chk("two_vld", 64'(sq_vld), 64'd1);
      chk("two_pc", 64'(sq_info.arch_pc), 64'h4);
      chk("two_tk", 64'(sq_info.branch_taken), 64'd0);
      tick();

      // wrap: {0,60} older than held {1,2}
      wb(0, 1'b1, 6'd2, 32'h12, 1'b0);
      tick();
      clr();
      wb(1, 1'b0, 6'd60, 32'h60, 1'b1);
      tick();
      clr();
      retire(1'b0, 6'd60);
      tick();
      clr();
      chk("wrap_vld", 64'(sq_vld), 64'd1);
      chk("wrap_pc", 64'(sq_info.arch_pc), 64'h60);
      tick();

      // same-index tie across ports: port0 wins
      wb(0, 1'b0, 6'd11, 32'hA0, 1'b0);
      wb(1, 1'b0, 6'd11, 32'hA1, 1'b0);
      tick();
      clr();
      // tie against held: held keeps its payload
      wb(1, 1'b0, 6'd11, 32'hA2, 1'b0);
      tick();
      clr();
      retire(1'b0, 6'd11);
      tick();
      clr();
      chk("tie_pc", 64'(sq_info.arch_pc), 64'hA0);
      tick();

      // candidate and matching retire in the same cycle
      wb(0, 1'b0, 6'd20, 32'h20, 1'b0);
      retire(1'b0, 6'd20);
      tick();
      bwb_vld = '0;
      chk("same_nx", 64'(sq_vld), 64'd0);
      chk("same_pend", 64'(pend), 64'd1);
      tick();
      clr();
      chk("same_fire", 64'(sq_vld), 64'd1);
      tick();

      // mispredict during FIRE is dropped
      wb(0, 1'b0, 6'd30, 32'h30, 1'b0);
      tick();
      retire(1'b0, 6'd30);
      bwb_vld = '0;
      tick();
      clr();
      chk("fire_vld", 64'(sq_vld), 64'd1);
      wb(0, 1'b0, 6'd3, 32'h3, 1'b0);
      tick();
      clr();
      chk("fire_ign", 64'(pend), 64'd0);
      tick();
      chk("fire_ign2", 64'(pend), 64'd0);

      // reset while pending discards the candidate
      wb(0, 1'b0, 6'd8, 32'h8, 1'b0);
      tick();
      clr();
      do_rst();
      chk("rp_pend", 64'(pend), 64'd0);
      retire(1'b0, 6'd8);
      tick();
      clr();
      chk("rp_novld", 64'(sq_vld), 64'd0);
      tick();
      chk("rp_novld2", 64'(sq_vld), 64'd0);

`ifdef SQUASH_GEN_VIOLATION_EN
      // load-store violation fires once head reaches the load
      vio_vld = 1'b1;
      vio_rob = '{flg: 1'b0, idx: 6'd7};
      vio_pc  = 32'h8000_0200;
      vio_st  = 8'h1A;
      vio_ld  = 8'h2B;
      tick();
      clr();
      retire(1'b0, 6'd7);
      tick();
      clr();
      chk("v_wait", 64'(sq_vld), 64'd0);
      head_rob = '{flg: 1'b0, idx: 6'd7};
      tick();
      clr();
      chk("v_vld", 64'(sq_vld), 64'd1);
      chk("v_dueV", 64'(sq_info.dueToViolation), 64'd1);
      chk("v_dueB", 64'(sq_info.dueToBranch), 64'd0);
      chk("v_pc", 64'(sq_info.arch_pc), 64'h8000_0200);
      chk("v_st", 64'(sq_info.st_foldpc), 64'h1A);
      chk("v_ld", 64'(sq_info.ld_foldpc), 64'h2B);
      tick();
      chk("v_off", 64'(sq_vld), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
